// File: rtl/ika32010_hostbridge_pkg.sv
// Shared constants for the IKA32010 host-memory bridge: DSP port map, status bits, host FSM states.
package ika32010_hostbridge_pkg;

   localparam logic [2:0] PORT_ADDR = 3'd0;
   localparam logic [2:0] PORT_DATA = 3'd1;
   localparam logic [2:0] PORT_STAT = 3'd2;

   localparam int STAT_RVLD = 0;
   localparam int STAT_FULL = 1;
   localparam int STAT_OVF  = 2;
   localparam int STAT_UNR  = 3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR   = 2'd1,
      S_RD   = 2'd2
   } host_st_t;

endpackage

// File: rtl/ika32010_hostbridge_wfifo.sv
// Posted-write FIFO: synchronous, DEPTH entries of DW bits, registered pointers.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: a push while full is ignored, and a pop while empty is ignored.
module ika32010_hostbridge_wfifo #(
   parameter int DW    = 29,
   parameter int DEPTH = 4
) (
   input  logic                       i_EMUCLK,
   input  logic                       i_RST,
   input  logic                       push_vld,
   input  logic [DW-1:0]              push_dat,
   input  logic                       pop_rdy,
   output logic [DW-1:0]              pop_dat,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     cnt
);
   localparam int PW = $clog2(DEPTH) + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic          push_ok;
   logic          pop_ok;

   // Extra pointer bit tells full from empty when the index bits match.
   assign cnt     = wptr - rptr;
   assign empty   = (wptr == rptr);
   assign full    = (cnt == PW'(DEPTH));
   assign push_ok = push_vld & ~full;
   assign pop_ok  = pop_rdy & ~empty;
   assign pop_dat = mem[rptr[PW-2:0]];

   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push_ok) wptr <= wptr + PW'(1);
         if (pop_ok)  rptr <= rptr + PW'(1);
      end
   end

   always_ff @(posedge i_EMUCLK) begin
      if (push_ok) mem[wptr[PW-2:0]] <= push_dat;
   end

endmodule

// File: rtl/ika32010_hostbridge.sv
// IKA32010 host bridge: address latch, posted-write/prefetch data port, status port; option IKA32010_HOSTBRIDGE_AUTOINC_EN.
// Latency: strobe edge acts on the next clock; host REQ rises one cycle later; rbuf valid the cycle after ACK.
// Backpressure: none toward the DSP; a full FIFO drops the word and flags overflow, BIO_n signals readiness.
module ika32010_hostbridge
   import ika32010_hostbridge_pkg::*;
#(
   parameter int AW          = 13,
   parameter int WFIFO_DEPTH = 4
) (
   input  logic          i_EMUCLK,
   input  logic          i_RST,
   input  logic [2:0]    i_DSP_AOUT,
   input  logic          i_DSP_WE_n,
   input  logic          i_DSP_DEN_n,
   input  logic [15:0]   i_DSP_DOUT,
   output logic [15:0]   o_DSP_DIN,
   output logic          o_DSP_DIN_OE,
   output logic          o_BIO_n,
   output logic          o_HOST_REQ,
   output logic          o_HOST_WR,
   output logic [AW-1:0] o_HOST_ADDR,
   output logic [15:0]   o_HOST_WDATA,
   input  logic          i_HOST_ACK,
   input  logic [15:0]   i_HOST_RDATA
);
   localparam int EW = AW + 16;
   localparam int PW = $clog2(WFIFO_DEPTH) + 1;

`ifdef IKA32010_HOSTBRIDGE_AUTOINC_EN
   localparam logic AUTOINC = 1'b1;
`else
   localparam logic AUTOINC = 1'b0;
`endif

   host_st_t      state;
   host_st_t      state_nxt;

   logic          we_q;
   logic          den_q;
   logic          we_fall;
   logic          den_rise;
   logic          addr_wr;
   logic          data_wr;
   logic          data_rd;
   logic          inval;

   logic [AW-1:0] addr;
   logic [15:0]   rbuf_dat;
   logic          rbuf_vld;
   logic          rbuf_vld_nxt;
   logic          pend;
   logic          stale;
   logic          ovf;
   logic          unr;
   logic          bio_n;

   logic          push_vld;
   logic          pop_rdy;
   logic [EW-1:0] head_dat;
   logic          fifo_full;
   logic          fifo_empty;
   logic [PW-1:0] fifo_cnt;
   logic [PW-1:0] cnt_nxt;

   logic          rd_take;
   logic [AW-1:0] host_addr;
   logic [15:0]   host_wdata;
   logic [15:0]   stat_dat;
   logic [15:0]   din_dat;
   logic          din_oe;

   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) begin
         we_q  <= 1'b1;
         den_q <= 1'b1;
      end else begin
         we_q  <= i_DSP_WE_n;
         den_q <= i_DSP_DEN_n;
      end
   end

   assign we_fall  = we_q & ~i_DSP_WE_n;
   assign den_rise = ~den_q & i_DSP_DEN_n;
   assign addr_wr  = we_fall & (i_DSP_AOUT == PORT_ADDR);
   assign data_wr  = we_fall & (i_DSP_AOUT == PORT_DATA);
   assign data_rd  = den_rise & (i_DSP_AOUT == PORT_DATA);
   assign inval    = addr_wr | data_wr | data_rd;

   // A full FIFO drops the word even if the head is popping this very cycle.
   assign push_vld = data_wr & ~fifo_full;
   assign pop_rdy  = (state == S_WR) & i_HOST_ACK;
   assign rd_take  = (state == S_RD) & i_HOST_ACK & ~stale & ~inval;

   ika32010_hostbridge_wfifo #(
      .DW    (EW),
      .DEPTH (WFIFO_DEPTH)
   ) u_wfifo (
      .i_EMUCLK (i_EMUCLK),
      .i_RST    (i_RST),
      .push_vld (push_vld),
      .push_dat ({addr, i_DSP_DOUT}),
      .pop_rdy  (pop_rdy),
      .pop_dat  (head_dat),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .cnt      (fifo_cnt)
   );

   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) begin
         addr     <= '0;
         rbuf_dat <= '0;
         rbuf_vld <= 1'b0;
         pend     <= 1'b0;
         ovf      <= 1'b0;
         unr      <= 1'b0;
      end else begin
         if (addr_wr)
            addr <= AW'(i_DSP_DOUT);
         else if (AUTOINC & (data_wr | data_rd))
            addr <= addr + AW'(1);

         if (inval) begin
            rbuf_vld <= 1'b0;
            pend     <= 1'b1;
         end else if (rd_take) begin
            rbuf_dat <= i_HOST_RDATA;
            rbuf_vld <= 1'b1;
            pend     <= 1'b0;
         end

         if (addr_wr) begin
            ovf <= 1'b0;
            unr <= 1'b0;
         end else begin
            if (data_wr & fifo_full) ovf <= 1'b1;
            if (data_rd & ~rbuf_vld) unr <= 1'b1;
         end
      end
   end

   // Any port event while a read is launching or in flight means its data no longer matches ADDR.
   always_ff @(posedge i_EMUCLK) begin
      if (i_RST)
         stale <= 1'b0;
      else if (state == S_IDLE)
         stale <= inval;
      else if ((state == S_RD) & inval)
         stale <= 1'b1;
   end

   always_ff @(posedge i_EMUCLK) begin
      if (i_RST)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (!fifo_empty)
               state_nxt = S_WR;
            else if (pend)
               state_nxt = S_RD;
         end
         S_WR:    if (i_HOST_ACK) state_nxt = S_IDLE;
         S_RD:    if (i_HOST_ACK) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) begin
         host_addr  <= '0;
         host_wdata <= '0;
      end else if (state == S_IDLE) begin
         if (state_nxt == S_WR)
            {host_addr, host_wdata} <= head_dat;
         else if (state_nxt == S_RD)
            host_addr <= addr;
      end
   end

   // BIO_n is computed from post-edge state so it falls together with rbuf_vld.
   assign rbuf_vld_nxt = inval ? 1'b0 : (rd_take | rbuf_vld);
   assign cnt_nxt      = fifo_cnt + PW'(push_vld) - PW'(pop_rdy);

   always_ff @(posedge i_EMUCLK) begin
      if (i_RST)
         bio_n <= 1'b1;
      else
         bio_n <= ~(rbuf_vld_nxt & (cnt_nxt == '0));
   end

   assign din_oe = ~i_DSP_DEN_n & (i_DSP_AOUT < 3'd3);

   always_comb begin
      stat_dat            = '0;
      stat_dat[STAT_RVLD] = rbuf_vld;
      stat_dat[STAT_FULL] = fifo_full;
      stat_dat[STAT_OVF]  = ovf;
      stat_dat[STAT_UNR]  = unr;
      din_dat             = '0;
      if (din_oe) begin
         case (i_DSP_AOUT)
            PORT_ADDR: din_dat = 16'(addr);
            PORT_DATA: din_dat = rbuf_dat;
            PORT_STAT: din_dat = stat_dat;
            default:   din_dat = '0;
         endcase
      end
   end

   assign o_DSP_DIN    = din_dat;
   assign o_DSP_DIN_OE = din_oe;
   assign o_BIO_n      = bio_n;
   assign o_HOST_REQ   = (state != S_IDLE);
   assign o_HOST_WR    = (state == S_WR);
   assign o_HOST_ADDR  = host_addr;
   assign o_HOST_WDATA = host_wdata;

endmodule

// File: tb/tb_ika32010_hostbridge.sv
// Directed bench for ika32010_hostbridge; expectations follow the address-increment option of the build.
module tb_ika32010_hostbridge;
   localparam int AW = 13;

`ifdef IKA32010_HOSTBRIDGE_AUTOINC_EN
   localparam int AI = 1;
`else
   localparam int AI = 0;
`endif

   logic          emuclk;
   logic          rst;
   logic [2:0]    dsp_aout;
   logic          dsp_we_n;
   logic          dsp_den_n;
   logic [15:0]   dsp_dout;
   logic [15:0]   dsp_din;
   logic          dsp_din_oe;
   logic          bio_n;
   logic          host_req;
   logic          host_wr;
   logic [AW-1:0] host_addr;
   logic [15:0]   host_wdata;
   logic          host_ack;
   logic [15:0]   host_rdata;

   int total = 0;
   int bad   = 0;

   ika32010_hostbridge #(.AW(AW), .WFIFO_DEPTH(4)) dut (
      .i_EMUCLK     (emuclk),
      .i_RST        (rst),
      .i_DSP_AOUT   (dsp_aout),
      .i_DSP_WE_n   (dsp_we_n),
      .i_DSP_DEN_n  (dsp_den_n),
      .i_DSP_DOUT   (dsp_dout),
      .o_DSP_DIN    (dsp_din),
      .o_DSP_DIN_OE (dsp_din_oe),
      .o_BIO_n      (bio_n),
      .o_HOST_REQ   (host_req),
      .o_HOST_WR    (host_wr),
      .o_HOST_ADDR  (host_addr),
      .o_HOST_WDATA (host_wdata),
      .i_HOST_ACK   (host_ack),
      .i_HOST_RDATA (host_rdata)
   );

   initial emuclk = 1'b0;
   always #5 emuclk = ~emuclk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge emuclk);
      #1;
   endtask

   task automatic dsp_out(input logic [2:0] port, input logic [15:0] d);
      dsp_aout = port;
      dsp_dout = d;
      dsp_we_n = 1'b0;
      tick(1);
      dsp_we_n = 1'b1;
      tick(1);
   endtask

   task automatic dsp_in(input logic [2:0] port, output logic [15:0] d, output logic oe);
      dsp_aout  = port;
      dsp_den_n = 1'b0;
      tick(1);
      d  = dsp_din;
      oe = dsp_din_oe;
      dsp_den_n = 1'b1;
      tick(1);
   endtask

   task automatic wait_req(input string tag);
      for (int i = 0; i < 50; i++) begin
         if (host_req) break;
         tick(1);
      end
      chk({tag, "_req"}, 32'(host_req), 32'd1);
   endtask

   task automatic host_ack_cyc(input logic [15:0] d);
      host_ack   = 1'b1;
      host_rdata = d;
      tick(1);
      host_ack   = 1'b0;
      host_rdata = '0;
   endtask

   task automatic serve_rd(input string tag, input int exp_addr, input logic [15:0] d);
      wait_req(tag);
      chk({tag, "_wr"}, 32'(host_wr), 32'd0);
      chk({tag, "_addr"}, 32'(host_addr), 32'(exp_addr));
      host_ack_cyc(d);
   endtask

   logic [15:0] rd;
   logic        oe;

   initial begin
      rst        = 1'b1;
      dsp_aout   = '0;
      dsp_we_n   = 1'b1;
      dsp_den_n  = 1'b1;
      dsp_dout   = '0;
      host_ack   = 1'b0;
      host_rdata = '0;
      tick(3);
      chk("rst_req", 32'(host_req), 0);
      chk("rst_wr", 32'(host_wr), 0);
      chk("rst_addr", 32'(host_addr), 0);
      chk("rst_wdata", 32'(host_wdata), 0);
      chk("rst_din", 32'(dsp_din), 0);
      chk("rst_oe", 32'(dsp_din_oe), 0);
      chk("rst_bio", 32'(bio_n), 1);
      rst = 1'b0;
      tick(1);
      dsp_in(3'd2, rd, oe);
      chk("rst_stat", 32'(rd), 0);
      chk("rst_stat_oe", 32'(oe), 1);

      // Basic prefetch after an address write
      dsp_out(3'd0, 16'h0123);
      wait_req("pf");
      chk("pf_wr", 32'(host_wr), 0);
      chk("pf_addr", 32'(host_addr), 32'h0123);
      chk("pf_bio_busy", 32'(bio_n), 1);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("pf_hold_req", 32'(host_req), 1);
         chk("pf_hold_addr", 32'(host_addr), 32'h0123);
      end
      host_ack_cyc(16'hBEEF);
      chk("pf_req_drop", 32'(host_req), 0);
      chk("pf_bio", 32'(bio_n), 0);
      dsp_in(3'd2, rd, oe);
      chk("pf_stat", 32'(rd), 32'h0001);
      dsp_in(3'd1, rd, oe);
      chk("pf_data", 32'(rd), 32'hBEEF);
      serve_rd("pf_next", 32'h0123 + AI, 16'h0000);

      // Sequential reads through the data port
      dsp_out(3'd0, 16'h0010);
      for (int k = 0; k < 3; k++) begin
         serve_rd("seq", 32'h10 + AI * k, 16'(32'h11 * (k + 1)));
         tick(1);
         dsp_in(3'd1, rd, oe);
         chk("seq_data", 32'(rd), 32'h11 * (k + 1));
      end
      serve_rd("seq_next", 32'h10 + AI * 3, 16'h0000);

      // Overflow of the posted-write FIFO
      dsp_out(3'd0, 16'h0040);
      serve_rd("ovf_pre", 32'h40, 16'h0000);
      for (int k = 0; k < 5; k++) dsp_out(3'd1, 16'(32'h100 + k));
      dsp_in(3'd2, rd, oe);
      chk("ovf_stat", 32'(rd), 32'h0006);
      for (int k = 0; k < 4; k++) begin
         wait_req("ovf_w");
         chk("ovf_w_wr", 32'(host_wr), 1);
         chk("ovf_w_addr", 32'(host_addr), 32'h40 + AI * k);
         chk("ovf_w_data", 32'(host_wdata), 32'h100 + k);
         host_ack_cyc(16'h0000);
         chk("ovf_w_gap", 32'(host_req), 0);
      end
      serve_rd("ovf_rd", 32'h40 + AI * 5, 16'h0077);
      tick(3);
      chk("ovf_no5th", 32'(host_req), 0);
      dsp_in(3'd2, rd, oe);
      chk("ovf_stat2", 32'(rd), 32'h0005);
      chk("ovf_bio", 32'(bio_n), 0);

      // Read-after-write coherence
      dsp_out(3'd0, 16'h0020);
      serve_rd("raw_pre", 32'h20, 16'h0000);
      dsp_out(3'd1, 16'h5555);
      dsp_out(3'd0, 16'h0020);
      wait_req("raw_w");
      chk("raw_w_wr", 32'(host_wr), 1);
      chk("raw_w_addr", 32'(host_addr), 32'h20);
      chk("raw_w_data", 32'(host_wdata), 32'h5555);
      host_ack_cyc(16'h0000);
      serve_rd("raw_rd", 32'h20, 16'h5555);
      dsp_in(3'd1, rd, oe);
      chk("raw_data", 32'(rd), 32'h5555);
      serve_rd("raw_next", 32'h20 + AI, 16'h0000);

      // Address rewrite during an in-flight read
      dsp_out(3'd0, 16'h0030);
      wait_req("stale");
      chk("stale_addr", 32'(host_addr), 32'h30);
      dsp_out(3'd0, 16'h0031);
      host_ack_cyc(16'hDEAD);
      dsp_in(3'd2, rd, oe);
      chk("stale_stat", 32'(rd), 32'h0000);
      serve_rd("stale_re", 32'h31, 16'h4242);
      dsp_in(3'd1, rd, oe);
      chk("stale_data", 32'(rd), 32'h4242);

      // Underrun: consume again before the next prefetch lands
      dsp_in(3'd1, rd, oe);
      chk("unr_data", 32'(rd), 32'h4242);
      dsp_in(3'd2, rd, oe);
      chk("unr_stat", 32'(rd), 32'h0008);
      chk("unr_req", 32'(host_req), 1);

      // Reset while a request is outstanding, then a late ACK
      rst = 1'b1;
      tick(1);
      chk("mrst_req", 32'(host_req), 0);
      chk("mrst_bio", 32'(bio_n), 1);
      rst = 1'b0;
      host_ack_cyc(16'hABCD);
      chk("mrst_late_req", 32'(host_req), 0);
      dsp_in(3'd2, rd, oe);
      chk("mrst_stat", 32'(rd), 32'h0000);
      chk("mrst_bio2", 32'(bio_n), 1);

      // Unused ports
      dsp_out(3'd6, 16'hFFFF);
      tick(3);
      chk("p6_req", 32'(host_req), 0);
      dsp_in(3'd5, rd, oe);
      chk("p5_data", 32'(rd), 0);
      chk("p5_oe", 32'(oe), 0);
      dsp_in(3'd1, rd, oe);
      chk("mrst_rbuf", 32'(rd), 32'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
